rca_pipe: RTL and testbench
===========================

// Module: rca_pipe
// PURPOSE
//  Parametrised, pipelined ripple-carry add/subtract unit. Generalises the 3-bit RCA.
//  - WIDTH-bit operands are split into STAGES equal chunks.
//  - Each chunk is a ripple chain of full adders, with a register between chunks.
//  - Supports add and subtract with carry/borrow in, plus carry-out and signed overflow.
//  - Sits between an operand producer and a result consumer, with valid/ready handshakes on both sides.
// PARAMETERS
//  WIDTH   8  operand/result width in bits; must be >= 1
//  STAGES  2  number of pipeline stages (equals latency); 1 <= STAGES <= WIDTH, WIDTH % STAGES == 0
// PORTS
//  clk        in   1      clock; all state updates on rising edge
//  rst        in   1      reset, asynchronous, active-high
//  in_valid   in   1      operand beat valid
//  in_ready   out  1      unit can accept an operand beat this cycle
//  a          in   WIDTH  operand A
//  b          in   WIDTH  operand B
//  cin        in   1      carry-in (add) / borrow-in (sub)
//  sub        in   1      0: add, 1: subtract
//  out_valid  out  1      result beat valid
//  out_ready  in   1      consumer accepts result this cycle
//  sum        out  WIDTH  result
//  cout       out  1      add: carry-out; sub: 1 = no borrow (a >= b+cin)
//  ovf        out  1      two's-complement signed overflow of the result
// BEHAVIOUR
//  - Arithmetic, with CW = WIDTH/STAGES:
//      - Effective B is b ^ {WIDTH{sub}); effective carry-in is cin ^ sub.
//      - {cout,sum} = a + effB + effCin, computed modulo 2^(WIDTH+1).
//      - sub=1 therefore gives sum = a - b - cin mod 2^WIDTH.
//      - ovf = (a[MSB] == effB[MSB]) && (sum[MSB] != a[MSB]).
//  - Stage k (0..STAGES-1) adds bits [k*CW +: CW] using the registered carry from stage k-1.
//      - Stage 0 uses effCin.
//      - Operand chunks still to be added are carried forward in skew registers.
//      - Completed chunks are carried forward alongside.
//  - Handshake:
//      - Beat transfer on in_valid && in_ready; result consumed on out_valid && out_ready.
//      - Global advance: adv = !out_valid || out_ready; in_ready = adv (combinational, no dependence on in_valid).
//      - When adv=1, every stage shifts one place. A stage loaded with no input beat becomes a bubble (valid bit 0).
//      - When adv=0, all stage registers and outputs hold, including sum/cout/ovf.
//      - in_valid may drop without a transfer; payload is sampled only on transfer.
//  - Latency: a beat accepted on edge N presents out_valid=1 after edge N+STAGES-1 when there is no stall, i.e. STAGES register stages.
//  - Throughput: 1 beat/cycle when out_ready is held at 1.
//  - Ordering: results leave in acceptance order; no drop, no duplicate.
//  - Simultaneous accept + emit in the same cycle is legal and keeps a full pipe full.
//  - Full pipe with out_ready=0: in_ready=0, nothing is accepted, and out_* is stable until consumed.
//  - Empty pipe: out_valid=0; sum/cout/ovf keep their last values (don't-care for the consumer).
//  - Reset (asynchronous assert, any cycle, including mid-operation):
//      - All stage valid bits clear; out_valid=0; sum=0, cout=0, ovf=0.
//      - In-flight beats are discarded.
//      - in_ready=1 from the first cycle after reset deassertion.
//  - STAGES=1: purely a registered adder. Result is registered one edge after accept, with the same handshake.
//  - Wrap-around: carries beyond bit WIDTH-1 go only to cout; no saturation.
// TESTING
//  (WIDTH=8, STAGES=2 unless stated)
//  1. add a=8'h0F, b=8'h01, cin=0, out_ready=1 -> 2nd edge after accept: sum=8'h10, cout=0, ovf=0.
//     Checks carry across the chunk boundary.
//  2. add 8'hFF+8'h01+cin=1 -> sum=8'h01, cout=1, ovf=0.
//     Then 8'h7F+8'h01 -> sum=8'h80, cout=0, ovf=1.
//  3. sub a=8'h05, b=8'h07, cin=0 -> sum=8'hFE, cout=0.
//     Then sub 8'h80-8'h01 -> sum=8'h7F, cout=1, ovf=1.
//  4. Stream 16 random beats back-to-back with out_ready randomly toggled.
//     Required: results match the reference model in order; in_ready == (!out_valid || out_ready) every cycle; outputs stable while stalled.
//  5. Fill the pipe with out_ready=0 -> in_ready=0 and held results unchanged for 10 cycles.
//     Then raise out_ready -> results drain one per cycle.
//  6. Assert rst mid-stream with 2 beats in flight -> out_valid=0 and sum/cout/ovf=0 immediately.
//     After release: no stale beat emerges; repeat with WIDTH=12, STAGES=3 and STAGES=1.

Source files
------------

// File: rtl/rca_pipe.sv
// Pipelined ripple-carry add/subtract unit: WIDTH bits split into STAGES chunks,
// one chunk of full adders per register stage, valid/ready handshakes on both sides.
module rca_pipe #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int unsigned CW   = WIDTH / STAGES;
  localparam int unsigned LAST = STAGES - 1;
  localparam int unsigned MSB  = WIDTH - 1;
  localparam int unsigned IW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  generate
    if (WIDTH < 1 || STAGES < 1 || STAGES > WIDTH || (WIDTH % STAGES) != 0) begin : g_bad_cfg
      $error("rca_pipe: illegal WIDTH/STAGES combination");
    end
  endgenerate

  // Stage registers: valid, chunk carry, skewed operands and partial sum
  logic [STAGES-1:0] v_q;
  logic [STAGES-1:0] c_q;
  logic [WIDTH-1:0]  a_q [STAGES];
  logic [WIDTH-1:0]  b_q [STAGES];
  logic [WIDTH-1:0]  s_q [STAGES];

  // Per-stage inputs (from ports for stage 0, from the previous register otherwise)
  logic              adv;
  logic [STAGES-1:0] v_in;
  logic [STAGES-1:0] c_in;
  logic [WIDTH-1:0]  a_in [STAGES];
  logic [WIDTH-1:0]  b_in [STAGES];
  logic [WIDTH-1:0]  s_in [STAGES];

  // Per-stage chunk results
  logic [CW:0]       rip  [STAGES];
  logic [STAGES-1:0] c_nx;
  logic [WIDTH-1:0]  s_nx [STAGES];

  // One chunk of full adders chained through the carry
  function automatic logic [CW:0] ripple(input logic [CW-1:0] x, input logic [CW-1:0] y,
                                         input logic ci);
    logic          c;
    logic [CW-1:0] s;
    c = ci;
    s = '0;
    for (int i = 0; i < int'(CW); i++) begin
      s[i] = x[i] ^ y[i] ^ c;
      c    = (x[i] & y[i]) | (c & (x[i] ^ y[i]));
    end
    return {c, s};
  endfunction

  // Whole pipe moves together; a full pipe only frees up when the consumer takes a beat
  assign adv      = !v_q[LAST] || out_ready;
  assign in_ready = adv;

  always_comb begin
    v_in[0] = in_valid;
    a_in[0] = a;
    b_in[0] = b ^ {WIDTH{sub}};
    c_in[0] = cin ^ sub;
    s_in[0] = '0;
    for (int k = 1; k < int'(STAGES); k++) begin
      v_in[k] = v_q[k-1];
      a_in[k] = a_q[k-1];
      b_in[k] = b_q[k-1];
      c_in[k] = c_q[k-1];
      s_in[k] = s_q[k-1];
    end
  end

  // Stage k adds its own chunk and merges it into the partial sum carried forward
  always_comb begin
    for (int k = 0; k < int'(STAGES); k++) begin
      rip[k]  = ripple(a_in[k][IW'(k * CW) +: CW], b_in[k][IW'(k * CW) +: CW], c_in[k]);
      c_nx[k] = rip[k][CW];
      s_nx[k] = s_in[k];
      s_nx[k][IW'(k * CW) +: CW] = rip[k][CW-1:0];
    end
  end

  // Payload registers load only behind a valid beat so bubbles leave results untouched
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v_q <= '0;
      c_q <= '0;
      for (int k = 0; k < int'(STAGES); k++) begin
        a_q[k] <= '0;
        b_q[k] <= '0;
        s_q[k] <= '0;
      end
    end else if (adv) begin
      v_q <= v_in;
      for (int k = 0; k < int'(STAGES); k++) begin
        if (v_in[k]) begin
          a_q[k] <= a_in[k];
          b_q[k] <= b_in[k];
          s_q[k] <= s_nx[k];
          c_q[k] <= c_nx[k];
        end
      end
    end
  end

  assign out_valid = v_q[LAST];
  assign sum       = s_q[LAST];
  assign cout      = c_q[LAST];
  // Overflow from the final stage flops: like-signed operands, result sign flipped
  assign ovf       = (a_q[LAST][MSB] == b_q[LAST][MSB]) && (s_q[LAST][MSB] != a_q[LAST][MSB]);

endmodule

// File: tb/tb_rca_pipe.sv
// Bench for rca_pipe: three configurations (8/2, 12/3, 8/1) driven with directed and
// random beats, checked every cycle against an integer-arithmetic reference model.
module tb_rca_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  localparam logic [7:0] DA [5] = '{8'h0F, 8'hFF, 8'h7F, 8'h05, 8'h80};
  localparam logic [7:0] DB [5] = '{8'h01, 8'h01, 8'h01, 8'h07, 8'h01};
  localparam logic       DC [5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
  localparam logic       DS [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};

  task automatic check(input string name, input longint unsigned act, input longint unsigned exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference: plain unsigned and signed integer arithmetic on w-bit values.
  // Returns {ovf, cout, sum[31:0]}.
  function automatic logic [33:0] model(input int unsigned w, input longint unsigned av,
                                        input longint unsigned bv, input logic c, input logic s);
    longint unsigned m, u, res;
    longint          sa, sb, sr, hi, lo;
    logic            co, o;
    m  = (64'd1 << w) - 64'd1;
    av = av & m;
    bv = bv & m;
    sa = (av > (m >> 1)) ? longint'(av) - longint'(m) - 64'sd1 : longint'(av);
    sb = (bv > (m >> 1)) ? longint'(bv) - longint'(m) - 64'sd1 : longint'(bv);
    if (s) begin
      res = (av - bv - 64'(c)) & m;
      co  = (av >= bv + 64'(c));
      sr  = sa - sb - longint'(64'(c));
    end else begin
      u   = av + bv + 64'(c);
      res = u & m;
      co  = (u > m);
      sr  = sa + sb + longint'(64'(c));
    end
    hi = longint'(m >> 1);
    lo = -hi - 64'sd1;
    o  = (sr > hi) || (sr < lo);
    return {o, co, 32'(res)};
  endfunction

  // Hand-computed values pinning the model
  initial begin : pins
    check("pin add 0F+01",      model(8,  64'h0F,  64'h01,  1'b0, 1'b0), {2'b00, 32'h10});
    check("pin add FF+01+1",    model(8,  64'hFF,  64'h01,  1'b1, 1'b0), {2'b01, 32'h01});
    check("pin add 7F+01",      model(8,  64'h7F,  64'h01,  1'b0, 1'b0), {2'b10, 32'h80});
    check("pin sub 05-07",      model(8,  64'h05,  64'h07,  1'b0, 1'b1), {2'b00, 32'hFE});
    check("pin sub 80-01",      model(8,  64'h80,  64'h01,  1'b0, 1'b1), {2'b11, 32'h7F});
    check("pin add12 FFF+001",  model(12, 64'hFFF, 64'h001, 1'b0, 1'b0), {2'b01, 32'h000});
    check("pin sub12 000-001-1",model(12, 64'h000, 64'h001, 1'b1, 1'b1), {2'b00, 32'hFFE});
  end

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int unsigned W = (g == 1) ? 12 : 8;
    localparam int unsigned S = (g == 0) ? 2 : ((g == 1) ? 3 : 1);

    logic         rst, in_valid, in_ready, cin, sub, out_valid, out_ready, cout, ovf;
    logic [W-1:0] a, b, sum;
    logic         done = 1'b0;
    logic         hold = 1'b0;
    logic [W+1:0] held = '0;
    logic [W+1:0] exp_q [$];

    rca_pipe #(.WIDTH(W), .STAGES(S)) u_dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
      .cin(cin), .sub(sub), .out_valid(out_valid), .out_ready(out_ready), .sum(sum),
      .cout(cout), .ovf(ovf)
    );

    function automatic logic [W+1:0] expv(input logic [W-1:0] va, input logic [W-1:0] vb,
                                          input logic vc, input logic vs);
      logic [33:0] r;
      r = model(W, 64'(va), 64'(vb), vc, vs);
      return {r[33], r[32], r[W-1:0]};
    endfunction

    // Compare process: sampled on the falling edge, away from the active edge
    always @(negedge clk) begin
      if (rst) begin
        check($sformatf("g%0d reset out_valid", g), out_valid, 0);
        check($sformatf("g%0d reset sum/cout/ovf", g), {ovf, cout, sum}, 0);
        exp_q.delete();
        hold <= 1'b0;
      end else begin
        check($sformatf("g%0d in_ready", g), in_ready, !out_valid || out_ready);
        if (hold) begin
          check($sformatf("g%0d stall out_valid", g), out_valid, 1);
          check($sformatf("g%0d stall data", g), {ovf, cout, sum}, held);
        end
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0)
            check($sformatf("g%0d beat with nothing outstanding", g), exp_q.size(), 1);
          else
            check($sformatf("g%0d result", g), {ovf, cout, sum}, exp_q.pop_front());
        end
        if (in_valid && in_ready) exp_q.push_back(expv(a, b, cin, sub));
        hold <= out_valid && !out_ready;
        held <= {ovf, cout, sum};
      end
    end

    task automatic push_beat(input logic [W-1:0] va, input logic [W-1:0] vb,
                             input logic vc, input logic vs, input bit rnd);
      bit took;
      int t;
      took = 1'b0;
      t    = 0;
      while (!took && t < 200) begin
        in_valid = 1'b1;
        a = va; b = vb; cin = vc; sub = vs;
        if (rnd) out_ready = 1'($urandom_range(0, 1));
        @(negedge clk);
        took = in_ready;
        @(posedge clk);
        #1;
        t++;
      end
      in_valid = 1'b0;
      if (!took) check($sformatf("g%0d accept timeout", g), took, 1);
    endtask

    task automatic idle(input int n, input bit rnd);
      for (int i = 0; i < n; i++) begin
        in_valid = 1'b0;
        a = W'($urandom());
        b = W'($urandom());
        cin = 1'($urandom());
        sub = 1'($urandom());
        if (rnd) out_ready = 1'($urandom_range(0, 1));
        @(posedge clk);
        #1;
      end
    endtask

    initial begin : drive
      rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      a = '0; b = '0; cin = 1'b0; sub = 1'b0;
      #1 rst = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      check($sformatf("g%0d in_ready after reset", g), in_ready, 1);
      check($sformatf("g%0d out_valid after reset", g), out_valid, 0);

      // Directed beats, back to back
      out_ready = 1'b1;
      for (int i = 0; i < 5; i++) push_beat(W'(DA[i]), W'(DB[i]), DC[i], DS[i], 1'b0);
      idle(S + 2, 1'b0);

      // Random stream with random consumer backpressure and input gaps
      for (int i = 0; i < 40; i++) begin
        if ($urandom_range(0, 3) == 0) idle(1, 1'b1);
        push_beat(W'($urandom()), W'($urandom()), 1'($urandom()), 1'($urandom()), 1'b1);
      end
      out_ready = 1'b1;
      idle(S + 2, 1'b0);

      // Fill with consumer stalled, hold for 10 cycles, then drain
      out_ready = 1'b0;
      for (int i = 0; i < int'(S); i++)
        push_beat(W'($urandom()), W'($urandom()), 1'($urandom()), 1'($urandom()), 1'b0);
      check($sformatf("g%0d full in_ready", g), in_ready, 0);
      in_valid = 1'b1;
      a = W'($urandom()); b = W'($urandom());
      for (int i = 0; i < 10; i++) begin
        @(negedge clk);
        check($sformatf("g%0d full stall in_ready", g), in_ready, 0);
        check($sformatf("g%0d full stall out_valid", g), out_valid, 1);
        @(posedge clk);
        #1;
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      for (int i = 0; i < int'(S); i++) begin
        @(negedge clk);
        check($sformatf("g%0d drain out_valid", g), out_valid, 1);
        @(posedge clk);
        #1;
      end
      @(negedge clk);
      check($sformatf("g%0d drained out_valid", g), out_valid, 0);
      @(posedge clk);
      #1;

      // Reset with two beats in flight
      push_beat(W'($urandom()), W'($urandom()), 1'b0, 1'b0, 1'b0);
      push_beat(W'($urandom()), W'($urandom()), 1'b1, 1'b1, 1'b0);
      rst = 1'b1;
      #1;
      check($sformatf("g%0d async reset out_valid", g), out_valid, 0);
      check($sformatf("g%0d async reset sum/cout/ovf", g), {ovf, cout, sum}, 0);
      @(posedge clk);
      #1 rst = 1'b0;
      check($sformatf("g%0d in_ready after mid reset", g), in_ready, 1);
      idle(2 * S + 3, 1'b0);
      for (int i = 0; i < 4; i++)
        push_beat(W'($urandom()), W'($urandom()), 1'($urandom()), 1'($urandom()), 1'b0);

      // Final drain
      out_ready = 1'b1;
      for (int t = 0; t < 50 && exp_q.size() != 0; t++) idle(1, 1'b0);
      check($sformatf("g%0d outstanding at end", g), exp_q.size(), 0);
      done = 1'b1;
    end
  end

  initial begin : finish_run
    fork
      wait (g_dut[0].done && g_dut[1].done && g_dut[2].done);
      #200000;
    join_any
    disable fork;
    check("run completion", {g_dut[0].done, g_dut[1].done, g_dut[2].done}, 3'b111);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
